// File: rtl/mem_a_loader.sv
// mem_a_loader: buffers a DEPTH-byte valid/ready frame in a FIFO, writes it to MemoryA at 0..DEPTH-1, pulses load_done
module mem_a_loader #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 3,
  parameter int DEPTH      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              hold,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              load_done
);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t            state_q, state_d;
  logic [PW-1:0]     rd_q, rd_d, wp_q, wp_d;
  logic [PW:0]       cnt_q, cnt_d;
  logic [ADDR_W:0]   acc_q, acc_d;
  logic [ADDR_W-1:0] wcnt_q, wcnt_d, wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic              wr_en_q, wr_en_d;
  logic              push, pop, full, empty, clear, last;
  assign full      = cnt_q == (PW+1)'(FIFO_DEPTH);
  assign empty     = cnt_q == '0;
  assign in_ready  = Reset && state_q == LOAD && !full && acc_q < (ADDR_W+1)'(DEPTH);
  assign push      = in_valid && in_ready;
  assign pop       = state_q == LOAD && !empty && !hold;
  assign clear     = state_q == IDLE && start;
  assign last      = wr_en_q && wr_addr_q == ADDR_W'(DEPTH-1);
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = state_q != IDLE;
  assign load_done = state_q == DONE;
  always_comb begin
    state_d   = state_q == IDLE ? (start ? LOAD : IDLE) : state_q == LOAD ? (last ? DONE : LOAD) : IDLE;
    rd_d      = clear ? '0 : rd_q + PW'(pop);
    wp_d      = clear ? '0 : wp_q + PW'(push);
    cnt_d     = clear ? '0 : cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    acc_d     = clear ? '0 : acc_q + (ADDR_W+1)'(push);
    wcnt_d    = clear ? '0 : wcnt_q + ADDR_W'(pop);
    wr_en_d   = pop;
    wr_addr_d = state_q == DONE ? '0 : pop ? wcnt_q : wr_addr_q;
    wr_data_d = pop ? mem_q[rd_q] : wr_data_q;
  end
  always_ff @(posedge clk) begin
    if (!Reset) begin
      state_q   <= IDLE;
      rd_q      <= '0;
      wp_q      <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      wcnt_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      wp_q      <= wp_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      wcnt_q    <= wcnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      if (push) mem_q[wp_q] <= in_data;
    end
  end
endmodule

// File: tb/tb_mem_a_loader.sv
// tb_mem_a_loader: table-driven cycle checks plus scoreboarded frame sequences for mem_a_loader
module tb_mem_a_loader;
  logic       clk = 1'b0;
  logic       Reset, start, in_valid, hold;
  logic [7:0] in_data;
  logic       in_ready, wr_en, busy, load_done;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  int pass_n = 0, total_n = 0;
  logic [10:0] sb[$];
  int wt[$];
  int cyc = 0, nwr = 0, ndone = 0, exp_idx = 0;
  logic last_acc;
  typedef struct {
    logic rst, st, v; logic [7:0] d; logic h;
    logic rdy, we; logic [2:0] a; logic [7:0] wd; logic b, ld;
  } vec_t;
  vec_t vec[15];
  mem_a_loader dut (
    .clk(clk), .Reset(Reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .hold(hold), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .load_done(load_done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", n, act, exp);
  endtask
  task automatic step();
    logic [2:0] ai;
    last_acc = in_valid && in_ready;
    @(posedge clk);
    if (last_acc) begin
      ai = 3'(exp_idx);
      sb.push_back({ai, in_data});
      exp_idx++;
    end
    #1;
    cyc++;
    if (load_done) ndone++;
    if (wr_en) begin
      nwr++;
      wt.push_back(cyc);
      chk("write_expected", sb.size() != 0, 1);
      if (sb.size() != 0) chk("write_addr_data", {wr_addr, wr_data}, sb.pop_front());
    end
  endtask
  task automatic begin_frame();
    sb.delete(); wt.delete();
    exp_idx = 0; nwr = 0; ndone = 0;
    start = 1; in_valid = 0; hold = 0;
    step();
    start = 0;
  endtask
  task automatic end_frame(input string n);
    chk({n, "_done"}, ndone, 1);
    chk({n, "_writes"}, nwr, 8);
    chk({n, "_sb_empty"}, sb.size(), 0);
    in_valid = 1; in_data = 8'h09;
    for (int k = 0; k < 4; k++) step();
    in_valid = 0;
    chk({n, "_single_done"}, ndone, 1);
    chk({n, "_no_extra_write"}, nwr, 8);
    chk({n, "_idle"}, {busy, in_ready}, 0);
  endtask
  task automatic run_frame(input logic [7:0] base, input int gap, input int restart_at, input string n);
    int i, c;
    begin_frame();
    i = 0; c = 0;
    while (ndone == 0 && c < 60) begin
      in_valid = (i < 8) && (c % gap == 0);
      in_data = base + 8'(i);
      start = (c == restart_at);
      step();
      if (last_acc) i++;
      c++;
    end
    start = 0;
    chk({n, "_accepts"}, i, 8);
    end_frame(n);
  endtask
  initial begin
    int i, c;
    vec[0]  = '{1'b0,1'b1,1'b1,8'hAA,1'b0, 1'b0,1'b0,3'd0,8'h00,1'b0,1'b0};
    vec[1]  = '{1'b0,1'b1,1'b1,8'hAA,1'b0, 1'b0,1'b0,3'd0,8'h00,1'b0,1'b0};
    vec[2]  = '{1'b1,1'b1,1'b0,8'h00,1'b0, 1'b0,1'b0,3'd0,8'h00,1'b1,1'b0};
    vec[3]  = '{1'b1,1'b0,1'b1,8'h01,1'b0, 1'b1,1'b0,3'd0,8'h00,1'b1,1'b0};
    for (int k = 4; k <= 10; k++)
      vec[k] = '{1'b1,1'b0,1'b1,8'(k-2),1'b0, 1'b1,1'b1,3'(k-4),8'(k-3),1'b1,1'b0};
    vec[11] = '{1'b1,1'b0,1'b1,8'h09,1'b0, 1'b0,1'b1,3'd7,8'h08,1'b1,1'b0};
    vec[12] = '{1'b1,1'b0,1'b1,8'h09,1'b0, 1'b0,1'b0,3'd7,8'h08,1'b1,1'b1};
    vec[13] = '{1'b1,1'b0,1'b1,8'h09,1'b0, 1'b0,1'b0,3'd0,8'h08,1'b0,1'b0};
    vec[14] = '{1'b1,1'b0,1'b1,8'h09,1'b0, 1'b0,1'b0,3'd0,8'h08,1'b0,1'b0};
    for (int k = 0; k < 15; k++) begin
      Reset = vec[k].rst; start = vec[k].st; in_valid = vec[k].v; in_data = vec[k].d; hold = vec[k].h;
      #1;
      chk($sformatf("row%0d_in_ready", k), in_ready, vec[k].rdy);
      @(posedge clk);
      #1;
      chk($sformatf("row%0d_wr_en", k), wr_en, vec[k].we);
      chk($sformatf("row%0d_wr_addr", k), wr_addr, vec[k].a);
      chk($sformatf("row%0d_wr_data", k), wr_data, vec[k].wd);
      chk($sformatf("row%0d_busy", k), busy, vec[k].b);
      chk($sformatf("row%0d_load_done", k), load_done, vec[k].ld);
    end
    in_valid = 0; start = 0;
    run_frame(8'h10, 2, -1, "gapped");
    begin_frame();
    hold = 1; i = 0;
    for (int k = 0; k < 8; k++) begin
      in_valid = i < 8; in_data = 8'h21 + 8'(i);
      step();
      if (last_acc) i++;
    end
    chk("hold_accepts", i, 4);
    chk("hold_in_ready", in_ready, 0);
    chk("hold_no_writes", nwr, 0);
    hold = 0; c = 0;
    while (ndone == 0 && c < 40) begin
      in_valid = i < 8; in_data = 8'h21 + 8'(i);
      step();
      if (last_acc) i++;
      c++;
    end
    chk("hold_total_accepts", i, 8);
    chk("hold_burst_consecutive", wt.size() >= 4 ? wt[3] - wt[0] : -1, 3);
    end_frame("hold");
    run_frame(8'h51, 1, 3, "restart_ignored");
    begin_frame();
    i = 0; c = 0;
    while (nwr < 3 && c < 30) begin
      in_valid = i < 8; in_data = 8'h31 + 8'(i);
      step();
      if (last_acc) i++;
      c++;
    end
    chk("mid_writes", nwr, 3);
    Reset = 0;
    #1;
    chk("mid_rst_in_ready", in_ready, 0);
    step();
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_addr", wr_addr, 0);
    Reset = 1; in_valid = 0;
    step();
    chk("mid_rst_quiet", wr_en, 0);
    run_frame(8'h41, 1, -1, "after_reset");
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule

// File: doc/mem_a_loader.md
Name: mem_a_loader

Overview:
Upstream stage of the memory-to-memory transfer path. Accepts a frame of DEPTH bytes from a valid/ready source and buffers them in a small FIFO. Writes them into MemoryA at contiguous addresses 0..DEPTH-1, then pulses load_done so the Controller can start the A-to-B transfer. A hold input stalls writes while MemoryA is being read.

Parameters:
DATA_W, 8, data width of source bytes and MemoryA words
ADDR_W, 3, MemoryA address width
DEPTH, 8, words per frame (must equal 2**ADDR_W)
FIFO_DEPTH, 4, skid/buffer FIFO entries (power of 2, >=2)

Ports:
clk  input  1  system clock, all logic on rising edge
Reset  input  1  synchronous, active-low reset (Reset==0 at a rising edge resets)
start  input  1  arm loading of a new frame; sampled only in IDLE
in_data  input  DATA_W  source byte
in_valid  input  1  source byte present
in_ready  output  1  loader accepts in_data this cycle
hold  input  1  1 = do not issue MemoryA writes this cycle
wr_en  output  1  MemoryA write enable (WEA)
wr_addr  output  ADDR_W  MemoryA write address
wr_data  output  DATA_W  MemoryA write data (DataInA)
busy  output  1  frame load in progress
load_done  output  1  one-cycle pulse: full frame written

Behaviour:
- Reset (Reset==0 at edge): state IDLE, FIFO flushed, accept and write counters 0. wr_en=0, wr_addr=0, wr_data=0, busy=0, load_done=0. in_ready=0 while reset is applied. Reset overrides all other inputs, including mid-frame: no further writes occur, and partially loaded data is abandoned.
- States: IDLE, LOAD, DONE.
- IDLE: in_ready=0, wr_en=0. If start=1 at edge, go to LOAD: busy=1, counters cleared.
- LOAD:
  - in_ready = !fifo_full && (accept_cnt < DEPTH). This is combinational from registered state only, never from in_valid.
  - Push on in_valid && in_ready; accept_cnt++.
  - Pop when FIFO non-empty and hold=0. At the same edge: wr_en<=1, wr_addr<=write_cnt, wr_data<=FIFO head, write_cnt++. Otherwise wr_en<=0; wr_addr and wr_data hold their last values.
  - Push and pop in the same cycle: occupancy unchanged, order preserved, no word lost or duplicated.
  - Latency: a byte accepted at edge N is written (wr_en high) in the cycle after edge N+1 if hold=0 and the FIFO was empty. Each hold cycle adds one cycle.
  - When the pop of the DEPTH-th word occurs, go to DONE.
- DONE (exactly one cycle): load_done=1, wr_en=0, in_ready=0, busy=1. Next edge: IDLE, busy=0, load_done=0, wr_addr=0.
- start while in LOAD or DONE is ignored.
- Bytes offered after DEPTH acceptances see in_ready=0 and are never consumed.
- write_cnt counts 0..DEPTH-1. Address DEPTH-1 is the last one written; no wrap within a frame.
- FIFO full: in_ready=0; no overwrite. FIFO empty: no pop, wr_en=0.
- hold=1 stalls pops only; acceptance continues until the FIFO is full.

Test Plan:
1. Hold Reset=0 for 2 cycles with start=1, in_valid=1 -> wr_en=0, wr_addr=0, wr_data=0, busy=0, load_done=0, in_ready=0, no writes.
2. Release reset, pulse start, stream 0x01..0x08 with in_valid=1 every cycle and hold=0 -> writes (addr,data) = (0,01)..(7,08) on 8 consecutive cycles. in_ready falls after the 8th accept. load_done is high for exactly one cycle following the write at addr 7, then busy=0.
3. Gapped source (in_valid alternating 1/0, data 0x10..0x17) -> 8 writes at contiguous addrs 0..7 with data 0x10..0x17 in order, no duplicates, single load_done.
4. hold=1 from start while the source streams 0x21..0x28 -> in_ready drops after exactly 4 accepts, wr_en stays 0. Release hold -> addrs 0..3 are written with 0x21..0x24 on consecutive cycles, then the remainder completes with 0x25..0x28 at addrs 4..7.
5. After a completed frame, keep in_valid=1 with 0x09 -> in_ready=0, 0x09 is never written. A second start pulse during LOAD of a new frame is ignored (exactly 8 writes, one load_done).
6. Drive Reset=0 after 3 writes of a frame (0x31..0x33 written at addrs 0..2) -> wr_en=0 from the next cycle, busy=0. A new start plus 0x41..0x48 -> writes restart at addr 0 with 0x41, and no stale FIFO data appears.
